// File: rtl/sort_buffer_if.sv
// sort_buffer_if: append stream into and sorted drain stream out of sort_buffer.
interface sort_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_ready, out_last;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/sort_buffer.sv
// sort_buffer: appends up to DEPTH values, sorts them in place by odd-even transposition, drains in order.
// Optional SORT_BUFFER_DESCEND_EN adds a desc input selecting descending order.
module sort_buffer #(
    parameter int  WIDTH  = 32,
    parameter int  DEPTH  = 16,
    parameter bit  SIGNED = 1'b0,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          sort_start,
`ifdef SORT_BUFFER_DESCEND_EN
    input  logic          desc,
`endif
    output logic          busy,
    output logic [CW-1:0] count,
    sort_buffer_if.slave  bus
);
    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] mem_nxt [DEPTH];
    logic [CW-1:0]    rd_ptr, phase, load_cnt;
    logic             desc_q, wr, rd, last;

    // Strict compare keeps equal values in arrival order.
    function automatic logic out_of_order(input logic [WIDTH-1:0] lo, hi, input logic d);
        logic gt, lt;
        gt = SIGNED ? ($signed(lo) > $signed(hi)) : (lo > hi);
        lt = SIGNED ? ($signed(lo) < $signed(hi)) : (lo < hi);
        return d ? lt : gt;
    endfunction

    assign bus.in_ready  = state == LOAD && count < CW'(DEPTH);
    assign bus.out_valid = state == DRAIN;
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign bus.out_last  = bus.out_valid && last;
    assign busy          = state == SORT;
    assign wr            = bus.in_valid && bus.in_ready;
    assign rd            = bus.out_valid && bus.out_ready;
    assign last          = rd_ptr == count - 1'b1;
    assign load_cnt      = count + CW'(wr);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    state_nxt = !sort_start ? LOAD : load_cnt > CW'(1) ? SORT : load_cnt == CW'(1) ? DRAIN : LOAD;
            SORT:    state_nxt = phase == count - 1'b1 ? DRAIN : SORT;
            DRAIN:   state_nxt = rd && last ? LOAD : DRAIN;
            default: state_nxt = LOAD;
        endcase
        if (flush) state_nxt = LOAD;
    end

    // Pairs in one phase never overlap, so every swap reads the current array.
    always_comb begin
        mem_nxt = mem;
        for (int i = 0; i < DEPTH - 1; i++)
            if (i[0] == phase[0] && i + 1 < int'(count) && out_of_order(mem[i], mem[i+1], desc_q)) begin
                mem_nxt[i]   = mem[i+1];
                mem_nxt[i+1] = mem[i];
            end
    end

    always_ff @(posedge clk)
        if (wr)                 mem[count[AW-1:0]] <= bus.in_data;
        else if (state == SORT) mem <= mem_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            phase  <= '0;
        end else begin
            count  <= flush || (rd && last) ? '0 : load_cnt;
            rd_ptr <= flush || (rd && last) ? '0 : rd ? rd_ptr + 1'b1 : rd_ptr;
            phase  <= state == SORT && !flush ? phase + 1'b1 : '0;
        end

`ifdef SORT_BUFFER_DESCEND_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) desc_q <= 1'b0;
        else        desc_q <= state == LOAD && sort_start ? desc : desc_q;
`else
    assign desc_q = 1'b0;
`endif
endmodule

// File: tb/tb_sort_buffer.sv
// tb_sort_buffer: random appends/sorts on an unsigned and a signed sort_buffer, drained output scoreboarded.
module tb_sort_buffer;
    localparam int DEPTH = 16;
    typedef logic [31:0] vq_t[$];
    typedef struct packed {logic [31:0] d; logic last;} exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, sort_start = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic        busy_a, busy_b;
    logic [4:0]  count_a, count_b;
    bit          rand_ready = 1'b0, ready_fixed = 1'b1;
    int          checks = 0, passes = 0;
    vq_t         model;
    exp_t        qa[$], qb[$];

    sort_buffer_if #(.WIDTH(32)) ifa ();
    sort_buffer_if #(.WIDTH(32)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifb.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifb.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;

    sort_buffer #(.WIDTH(32), .DEPTH(DEPTH), .SIGNED(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .sort_start(sort_start),
`ifdef SORT_BUFFER_DESCEND_EN
        .desc(1'b0),
`endif
        .busy(busy_a), .count(count_a), .bus(ifa.slave));
    sort_buffer #(.WIDTH(32), .DEPTH(DEPTH), .SIGNED(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .sort_start(sort_start),
`ifdef SORT_BUFFER_DESCEND_EN
        .desc(1'b0),
`endif
        .busy(busy_b), .count(count_b), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit lt(input logic [31:0] a, b, input bit sgn);
        return sgn ? ($signed(a) < $signed(b)) : (a < b);
    endfunction

    // Stable insertion sort of everything appended so far, queued as the expected drain.
    function automatic void load_expect();
        vq_t s;
        for (int k = 0; k < 2; k++) begin
            s = {};
            foreach (model[j]) begin
                int i = s.size();
                while (i > 0 && lt(model[j], s[i-1], k == 1)) i--;
                s.insert(i, model[j]);
            end
            foreach (s[j])
                if (k == 0) qa.push_back('{d: s[j], last: j == s.size() - 1});
                else        qb.push_back('{d: s[j], last: j == s.size() - 1});
        end
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    logic [31:0] hold_a, hold_b;
    bit          wait_a = 1'b0, wait_b = 1'b0;
    exp_t        e;
    always @(negedge clk) begin
        if (wait_a && ifa.out_valid) check("hold_a", ifa.out_data, hold_a);
        if (wait_b && ifb.out_valid) check("hold_b", ifb.out_data, hold_b);
        wait_a = ifa.out_valid && !ifa.out_ready;
        wait_b = ifb.out_valid && !ifb.out_ready;
        hold_a = ifa.out_data;
        hold_b = ifb.out_data;
        if (ifa.out_valid && ifa.out_ready) begin
            check("a_expected", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_data", ifa.out_data, e.d);
                check("a_last", 32'(ifa.out_last), 32'(e.last));
            end
        end
        if (ifb.out_valid && ifb.out_ready) begin
            check("b_expected", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_data", ifb.out_data, e.d);
                check("b_last", 32'(ifb.out_last), 32'(e.last));
            end
        end
    end

    task automatic push(input logic [31:0] v);
        in_valid = 1'b1;
        in_data  = v;
        check("in_ready", 32'(ifa.in_ready), 32'(model.size() < DEPTH));
        if (model.size() < DEPTH) model.push_back(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_sort(input bit with_wr, input logic [31:0] v);
        int n, k;
        if (with_wr) begin
            in_valid = 1'b1;
            in_data  = v;
            if (model.size() < DEPTH) model.push_back(v);
        end
        sort_start = 1'b1;
        n = model.size();
        load_expect();
        model = {};
        step();
        in_valid   = 1'b0;
        sort_start = 1'b0;
        check("busy", 32'(busy_a), 32'(n >= 2));
        if (n == 0) begin
            step();
            check("idle_valid", 32'(ifa.out_valid), 0);
            check("idle_count", 32'(count_a), 0);
            return;
        end
        k = 0;
        while (!ifa.out_valid && k < 64) begin step(); k++; end
        check("latency", k, n >= 2 ? n : 0);
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 4000) begin step(); k++; end
        check("drained", qa.size() + qb.size(), 0);
        check("count_after", 32'(count_a), 0);
    endtask

    initial begin
        int n, k;
        #12;
        check("rst_busy", 32'(busy_a), 0);
        check("rst_valid", 32'(ifa.out_valid), 0);
        check("rst_last", 32'(ifa.out_last), 0);
        check("rst_data", ifa.out_data, 0);
        check("rst_in_ready", 32'(ifa.in_ready), 1);
        check("rst_count", 32'(count_b), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        // Two-stage append then sort
        repeat (10) push($urandom);
        repeat (5) push($urandom);
        check("t1_count", 32'(count_a), 15);
        do_sort(1'b0, '0);
        // Overfill
        repeat (17) push($urandom);
        check("t2_count", 32'(count_a), 16);
        check("t2_in_ready", 32'(ifa.in_ready), 0);
        do_sort(1'b0, '0);
        // Duplicates with random backpressure
        rand_ready = 1'b1;
        push(5); push(3); push(5); push(1);
        do_sort(1'b0, '0);
        // Signed vs unsigned order
        push(-2); push(7); push(0);
        do_sort(1'b1, -9);
        rand_ready = 1'b0;
        // Empty and single-entry sorts
        do_sort(1'b0, '0);
        push(32'h1234);
        do_sort(1'b0, '0);
        // Flush on the third SORT cycle
        repeat (6) push($urandom);
        sort_start = 1'b1;
        step();
        sort_start = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model = {};
        check("flush_busy", 32'(busy_a), 0);
        check("flush_count", 32'(count_a), 0);
        check("flush_valid", 32'(ifa.out_valid), 0);
        push(9); push(4);
        do_sort(1'b0, '0);
        // Async reset while draining with the consumer stalled
        ready_fixed = 1'b0;
        step();
        repeat (5) push($urandom);
        sort_start = 1'b1;
        step();
        sort_start = 1'b0;
        model = {};
        k = 0;
        while (!ifa.out_valid && k < 64) begin step(); k++; end
        check("pre_rst_valid", 32'(ifa.out_valid), 1);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ifa.out_valid), 0);
        check("mid_rst_valid_b", 32'(ifb.out_valid), 0);
        check("mid_rst_data", ifa.out_data, 0);
        check("mid_rst_count", 32'(count_a), 0);
        qa = {};
        qb = {};
        ready_fixed = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        // Random rounds
        for (int r = 0; r < 25; r++) begin
            bit narrow;
            n = $urandom_range(0, 18);
            narrow = 1'($urandom_range(0, 1));
            rand_ready = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) push(narrow ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom);
            do_sort(1'($urandom_range(0, 1)), narrow ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom);
        end
        step();
        check("final_queues", qa.size() + qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
